// File: rtl/omsp_sha512_driver.sv
// omsp_sha512_driver
// Hardware initiator for the SHA-512 frontend. It streams msg_len bytes, one
// 16-bit memory word per beat, from msg_base into the frontend. It waits for
// the digest, then reads the digest back as 32 x 16-bit words.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start, msg_base, msg_len    request (sampled only in IDLE)
//   mem_rd, mem_addr, mem_rdata word memory read port (1-cycle read latency)
//   sha_cmd, sha_data, sha_data_size, sha_busy, sha_ready, sha_hash
//                               frontend command/data/hash port
//   hash_we, hash_idx, hash_word digest word output stream
//   busy, done, err             status
module omsp_sha512_driver #(
  parameter int ADDR_W   = 16,
  parameter int HASH_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] msg_base,
  input  logic [ADDR_W-1:0] msg_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [1:0]        sha_cmd,
  output logic [15:0]       sha_data,
  output logic              sha_data_size,
  input  logic              sha_busy,
  input  logic              sha_ready,
  input  logic [15:0]       sha_hash,
  output logic              hash_we,
  output logic [4:0]        hash_idx,
  output logic [15:0]       hash_word,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_STALL, S_FLUSH, S_WAIT, S_READ, S_DRAIN, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   beats_q;      // beats still to issue
  logic                odd_q;        // last beat carries a single byte
  logic                first_q;      // next beat is the first of the message
  logic                err_q;
  logic                wr_d1_q;      // previous cycle issued a WRITE beat
  logic                half_d1_q;    // that beat was the odd final byte
  logic [4:0]          rd_cnt_q;
  logic [4:0]          hidx_q;
  logic [HASH_LAT-1:0] hpipe_q;      // READ cycle -> hash word valid delay line

  logic issue;   // WRITE beat issued this cycle
  logic rd;      // READ command this cycle
  logic last_beat;

  assign last_beat = (beats_q == ADDR_W'(1));
  assign hash_we   = hpipe_q[HASH_LAT-1];

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    rd      = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (msg_len == '0) ? S_DONE : S_WRITE;
      // The first beat goes out unconditionally; later ones need sha_ready.
      S_WRITE: begin
        if (first_q || sha_ready) begin
          issue = 1'b1;
          if (last_beat) state_d = S_FLUSH;
        end else begin
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (sha_ready) begin
          issue   = 1'b1;
          state_d = last_beat ? S_FLUSH : S_WRITE;
        end
      end
      S_FLUSH: state_d = S_WAIT;
      S_WAIT:  if (!sha_busy) state_d = S_READ;
      S_READ: begin
        rd = 1'b1;
        if (rd_cnt_q == 5'd31) state_d = S_DRAIN;
      end
      S_DRAIN: if (hash_we && hidx_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      beats_q   <= '0;
      odd_q     <= 1'b0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_d1_q   <= 1'b0;
      half_d1_q <= 1'b0;
      rd_cnt_q  <= '0;
      hidx_q    <= '0;
      hpipe_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        addr_q  <= msg_base;
        beats_q <= (msg_len >> 1) + ADDR_W'(msg_len[0]);
        odd_q   <= msg_len[0];
        first_q <= 1'b1;
        err_q   <= (msg_len == '0);
      end else if (issue) begin
        addr_q  <= addr_q + ADDR_W'(1);   // wraps silently
        beats_q <= beats_q - ADDR_W'(1);
        first_q <= 1'b0;
      end
      wr_d1_q   <= issue;
      half_d1_q <= issue && last_beat && odd_q;
      if (rd) rd_cnt_q <= rd_cnt_q + 5'd1;  // 32 reads wrap back to 0
      if (hash_we) hidx_q <= hidx_q + 5'd1;
      hpipe_q[0] <= rd;
      for (int i = 1; i < HASH_LAT; i++) hpipe_q[i] <= hpipe_q[i-1];
    end
  end

  assign mem_rd        = issue;
  assign mem_addr      = addr_q;
  assign sha_cmd       = {issue, rd};
  // Memory data arrives one cycle after the read, aligned with the data slot.
  assign sha_data      = wr_d1_q ? mem_rdata : 16'h0;
  assign sha_data_size = wr_d1_q & ~half_d1_q;
  assign hash_idx      = hidx_q;
  assign hash_word     = hash_we ? sha_hash : 16'h0;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_DONE) & err_q;

endmodule
